reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//  - General-purpose register file of the REDUX-V core: REG_SIZE registers, each BITS wide.
//  - Two independent asynchronous read ports (A, B) feed the ALU operands.
//  - One synchronous write port takes the writeback result.
//  - Sits between decode (addresses) and execute/writeback (data).
// PARAMETERS
//  - BITS      8  width of each register and of every data port
//  - REG_BITS  2  width of every address port
//  - REG_SIZE  4  number of registers; must equal 2**REG_BITS
// PORTS
//  - clk            in   1         single clock; all state updates on rising edge
//  - reset          in   1         asynchronous, active-high reset
//  - write_enable   in   1         1 = write write_data into write_address at next rising clk
//  - write_address  in   REG_BITS  destination register index
//  - write_data     in   BITS      value to store
//  - address_a      in   REG_BITS  read port A index
//  - address_b      in   REG_BITS  read port B index
//  - data_a         out  BITS      contents of register[address_a]
//  - data_b         out  BITS      contents of register[address_b]
// BEHAVIOUR
//  - Reset:
//    - Asynchronous and active-high; clears every register to 0 immediately, with no clock needed.
//    - data_a and data_b therefore read 0 during and after reset.
//    - Reset asserted mid-write wins: the write is discarded.
//  - Write:
//    - On rising clk with reset=0 and write_enable=1, register[write_address] <= write_data.
//    - Registers not addressed hold their value; write_enable=0 changes nothing.
//  - Register 0 is an ordinary writable register (not hardwired to zero).
//  - Read:
//    - Purely combinational: data_x = register[address_x], zero cycles of latency.
//    - An address change is reflected within the same cycle.
//    - A write is visible on the read ports immediately after the rising edge that performs it.
//    - Both ports may address the same register simultaneously; both return the same value.
//  - Read-during-write (same address, same cycle, before the edge):
//    - Default: the read returns the old value.
//    - The new value appears after the edge (see CONFIGURATION).
//  - Addresses span exactly 0..REG_SIZE-1; no out-of-range case exists; all-ones is the last register.
//  - Data width is exact: no sign extension or truncation; write_data 0xFF is stored as 0xFF.
// CONFIGURATION
//  - Macro REG_BANK_BYPASS_EN:
//    - Defined: internal write-to-read forwarding. When write_enable=1 and write_address==address_x,
//      data_x shows write_data combinationally in the same cycle, independently per port.
//    - Undefined: no forwarding; reads always reflect stored contents (old value before the edge).
// STRUCTURE
//  - Shared package/header (utils.vh):
//    - BITS, REG_BITS, REG_SIZE constants.
//    - Register-index and data-word typedefs (or width macros).
//    - The equality-check ASSERT macro used by benches.
//  - One sub-module, reg_bank_read_port: mux of the register array by address, plus an optional
//    bypass compare; instantiated twice (A, B).
//  - Storage is a flat array of REG_SIZE x BITS flops with async clear; no memory inference.
// TESTING
//  - Reset:
//    - Write 0x5A to r2.
//    - Pulse reset asynchronously between edges.
//    - Expect data_a (addr 2) = 0x00 at once, before the next clk edge.
//  - Write sweep:
//    - For each r0..r3 write value v (0x00, 0x01, ... 0xFF over repeated passes).
//    - After each edge, address_a=last written -> v.
//    - address_b=previous index (wrapping 0->3) -> its value from the earlier write.
//  - Write disabled:
//    - write_enable=0, write_address=1, write_data=0xAA for several edges.
//    - Expect r1 unchanged (e.g. still 0x07).
//  - Dual same-address read: r3=0xFF, address_a=address_b=3 -> data_a=data_b=0xFF.
//  - Read-during-write at r1 (old value 0x10, write_data 0x20):
//    - Without REG_BANK_BYPASS_EN: 0x10 before the edge, 0x20 after.
//    - With the macro: 0x20 before the edge.
//  - Wrap boundary: write 0xFF to r3, then 0x00 to r0 -> both held independently and read correctly.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared constants and typedefs for the REDUX-V register bank
//
// Contents:
//   REG_BANK_BITS      data word width
//   REG_BANK_REG_BITS  register index width
//   REG_BANK_REG_SIZE  register count (always 2**REG_BANK_REG_BITS)
//   reg_idx_t          register index type
//   data_word_t        data word type
// Optional feature macro used by this slice: REG_BANK_BYPASS_EN

package reg_bank_pkg;

  localparam int REG_BANK_BITS     = 8;
  localparam int REG_BANK_REG_BITS = 2;
  localparam int REG_BANK_REG_SIZE = 1 << REG_BANK_REG_BITS;

  typedef logic [REG_BANK_REG_BITS-1:0] reg_idx_t;
  typedef logic [REG_BANK_BITS-1:0]     data_word_t;

endpackage

// File: rtl/reg_bank_read_port.sv
// rtl/reg_bank_read_port.sv - one asynchronous read port of the register bank
//
// Ports:
//   regs           in   flat register array, REG_SIZE x BITS
//   address        in   register index to read
//   reset          in   bank reset (bypass only; reads must show 0 during reset)
//   write_enable   in   writeback strobe (bypass only)
//   write_address  in   writeback index (bypass only)
//   write_data     in   writeback value (bypass only)
//   data           out  regs[address], or write_data when forwarding
// Macro REG_BANK_BYPASS_EN: defined -> same-cycle write-to-read forwarding.

module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int BITS     = REG_BANK_BITS,
  parameter int REG_BITS = REG_BANK_REG_BITS,
  parameter int REG_SIZE = REG_BANK_REG_SIZE
) (
  input  logic [REG_SIZE-1:0][BITS-1:0] regs,
  input  logic [REG_BITS-1:0]           address,
`ifdef REG_BANK_BYPASS_EN
  input  logic                          reset,
  input  logic                          write_enable,
  input  logic [REG_BITS-1:0]           write_address,
  input  logic [BITS-1:0]               write_data,
`endif
  output logic [BITS-1:0]               data
);

  logic [BITS-1:0] stored;

  assign stored = regs[address];

`ifdef REG_BANK_BYPASS_EN
  // Forward the in-flight writeback value so the ALU sees it this cycle.
  // Reset suppresses forwarding because the pending write will be discarded.
  always_comb begin
    data = stored;
    if (write_enable && !reset && (write_address == address))
      data = write_data;
  end
`else
  assign data = stored;
`endif

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - REDUX-V general-purpose register file, 2 async read ports, 1 sync write port
//
// Ports:
//   clk            in   rising-edge clock for writes
//   reset          in   asynchronous active-high clear of every register
//   write_enable   in   1 = store write_data at the next rising edge
//   write_address  in   destination register index
//   write_data     in   value to store
//   address_a      in   read port A index
//   address_b      in   read port B index
//   data_a         out  register[address_a], combinational
//   data_b         out  register[address_b], combinational
// Macro REG_BANK_BYPASS_EN: defined -> both read ports forward a same-cycle write.

module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int BITS     = REG_BANK_BITS,
  parameter int REG_BITS = REG_BANK_REG_BITS,
  parameter int REG_SIZE = REG_BANK_REG_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [REG_BITS-1:0] write_address,
  input  logic [BITS-1:0]     write_data,
  input  logic [REG_BITS-1:0] address_a,
  input  logic [REG_BITS-1:0] address_b,
  output logic [BITS-1:0]     data_a,
  output logic [BITS-1:0]     data_b
);

  // Flat flop array; packed so it passes straight into the read ports.
  logic [REG_SIZE-1:0][BITS-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      regs <= '0;
    else if (write_enable)
      regs[write_address] <= write_data;
  end

  reg_bank_read_port #(
    .BITS     (BITS),
    .REG_BITS (REG_BITS),
    .REG_SIZE (REG_SIZE)
  ) u_port_a (
    .regs          (regs),
    .address       (address_a),
`ifdef REG_BANK_BYPASS_EN
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
`endif
    .data          (data_a)
  );

  reg_bank_read_port #(
    .BITS     (BITS),
    .REG_BITS (REG_BITS),
    .REG_SIZE (REG_SIZE)
  ) u_port_b (
    .regs          (regs),
    .address       (address_b),
`ifdef REG_BANK_BYPASS_EN
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
`endif
    .data          (data_b)
  );

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - scoreboard bench for reg_bank (both REG_BANK_BYPASS_EN builds)

module tb_reg_bank;
  import reg_bank_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_enable = 1'b0;
  reg_idx_t   write_address = '0;
  data_word_t write_data = '0;
  reg_idx_t   address_a = '0;
  reg_idx_t   address_b = '0;
  data_word_t data_a;
  data_word_t data_b;

  reg_bank dut (
    .clk           (clk),
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .address_a     (address_a),
    .address_b     (address_b),
    .data_a        (data_a),
    .data_b        (data_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    data_word_t exp_a;
    data_word_t exp_b;
    bit         chk_b;
  } exp_t;

  exp_t       sb_q[$];
  logic       strobe = 1'b0;
  int         checks = 0;
  int         errors = 0;
  data_word_t model [REG_BANK_REG_SIZE];

  // Monitor: each strobe marks a moment where the read ports are presented.
  always @(posedge strobe) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: strobe with no expected entry");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (data_a !== e.exp_a) begin
        errors++;
        $display("FAIL %s data_a: got %02h expected %02h", e.name, data_a, e.exp_a);
      end
      if (e.chk_b) begin
        checks++;
        if (data_b !== e.exp_b) begin
          errors++;
          $display("FAIL %s data_b: got %02h expected %02h", e.name, data_b, e.exp_b);
        end
      end
    end
  end

  task automatic expect_rd(input string name, input data_word_t ea,
                           input data_word_t eb, input bit cb);
    exp_t e;
    #1;
    e.name = name; e.exp_a = ea; e.exp_b = eb; e.chk_b = cb;
    sb_q.push_back(e);
    strobe = 1'b1;
    #1;
    strobe = 1'b0;
  endtask

  // Drive a write at a negedge; the following posedge performs it.
  task automatic do_write(input reg_idx_t a, input data_word_t d);
    @(negedge clk);
    write_enable = 1'b1; write_address = a; write_data = d;
    @(negedge clk);
    write_enable = 1'b0;
    model[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    foreach (model[i]) model[i] = '0;

    // Power-on reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    address_a = 2'd0; address_b = 2'd3;
    expect_rd("reset_r0_r3", 8'h00, 8'h00, 1'b1);

    // Asynchronous reset between edges
    do_write(2'd2, 8'h5A);
    address_a = 2'd2; address_b = 2'd1;
    expect_rd("pre_reset_r2", 8'h5A, 8'h00, 1'b1);
    #1 reset = 1'b1;
    expect_rd("async_reset_r2", 8'h00, 8'h00, 1'b1);
    #1 reset = 1'b0;
    model[2] = '0;

    // Reset asserted during a pending write discards it
    @(negedge clk);
    write_enable = 1'b1; write_address = 2'd2; write_data = 8'h33;
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    reset = 1'b0;
    address_a = 2'd2;
    expect_rd("reset_beats_write", 8'h00, 8'h00, 1'b0);

    // Write sweep: value i into r(i mod 4), read back current and previous index
    for (int i = 0; i < 256; i++) begin
      reg_idx_t cur, prev;
      cur  = reg_idx_t'(i);
      prev = reg_idx_t'(i - 1);
      do_write(cur, data_word_t'(i));
      address_a = cur; address_b = prev;
      expect_rd("sweep", data_word_t'(i), (i == 0) ? 8'h00 : data_word_t'(i - 1), 1'b1);
    end
    // Hand-computed end state of the sweep
    address_a = 2'd0; address_b = 2'd2;
    expect_rd("sweep_end_r0_r2", 8'hFC, 8'hFE, 1'b1);

    // Write disabled
    do_write(2'd1, 8'h07);
    write_enable = 1'b0; write_address = 2'd1; write_data = 8'hAA;
    address_a = 2'd1; address_b = 2'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_rd("write_disabled_r1", 8'h07, 8'hFF, 1'b1);
    end

    // Dual same-address read
    do_write(2'd3, 8'hFF);
    address_a = 2'd3; address_b = 2'd3;
    expect_rd("dual_read_r3", 8'hFF, 8'hFF, 1'b1);

    // Read-during-write at r1
    do_write(2'd1, 8'h10);
    address_a = 2'd1; address_b = 2'd2;
    write_enable = 1'b1; write_address = 2'd1; write_data = 8'h20;
`ifdef REG_BANK_BYPASS_EN
    expect_rd("rdw_before_edge", 8'h20, 8'hFE, 1'b1);
`else
    expect_rd("rdw_before_edge", 8'h10, 8'hFE, 1'b1);
`endif
    @(negedge clk);
    write_enable = 1'b0;
    expect_rd("rdw_after_edge", 8'h20, 8'hFE, 1'b1);

    // Wrap boundary: last and first registers held independently
    do_write(2'd3, 8'hFF);
    do_write(2'd0, 8'h00);
    address_a = 2'd3; address_b = 2'd0;
    expect_rd("wrap_r3_r0", 8'hFF, 8'h00, 1'b1);
    address_a = 2'd0; address_b = 2'd3;
    expect_rd("wrap_swap", 8'h00, 8'hFF, 1'b1);

    // Drain: bounded wait for the monitor to consume every entry
    for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
